// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - handshake/bus bundle between the fetch stage, its control, and instruction memory
//
// Purpose: groups every fetch-stage signal except clock and reset.
// Signals:
//   stall_i        hold PC and IF/ID contents
//   flush_i        load a bubble into IF/ID
//   redirect_i     load redirect_pc_i into PC (branch/jump taken)
//   redirect_pc_i  redirect target address
//   imem_addr_o    instruction memory address, equals the current PC
//   imem_rd_i      instruction word read combinationally at imem_addr_o
//   ifid_instr_o   registered instruction
//   ifid_pc_o      PC of ifid_instr_o
//   ifid_pc4_o     ifid_pc_o + 4
//   ifid_valid_o   IF/ID holds a real instruction (0 = bubble)
//   fault_o        00 none, 01 misaligned PC, 10 PC out of range (sticky)
//   fetch_count_o  number of valid instructions loaded into IF/ID
// Modports: slave = fetch stage side, master = control/memory side.
interface fetch_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rd_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [1:0]  fault_o;
  logic [31:0] fetch_count_o;

  modport slave (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_rd_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o,
           ifid_valid_o, fault_o, fetch_count_o
  );

  modport master (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_rd_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o,
           ifid_valid_o, fault_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect/stall/flush, fetch fault trap
//
// Purpose: owns the PC, drives the instruction memory address, captures the returned
//          word into the IF/ID register, and traps misaligned or out-of-range fetches
//          (halting until reset).
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   if_fetch fetch_stage_if.slave bundle (controls in, memory read data in,
//            memory address / IF/ID / fault / count out)
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  if_fetch
);

  // One bit wider than the PC so the bound itself never wraps.
  localparam logic [32:0] LP_PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic [1:0]  r_fault;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic        w_misaligned;
  logic        w_out_of_range;

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_misaligned   = (r_pc[1:0] != 2'b00);
  assign w_out_of_range = ({1'b0, r_pc} >= LP_PC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_ifid_instr  <= 32'd0;
      r_ifid_pc     <= 32'd0;
      r_ifid_pc4    <= 32'd0;
      r_ifid_valid  <= 1'b0;
      r_fault       <= 2'b00;
      r_fetch_count <= 32'd0;
    end else begin
      case (r_state)
        // First edge after reset release: PC held, nothing captured.
        ST_BOOT: r_state <= ST_RUN;

        ST_RUN: begin
          // The fault check looks at the PC being presented now, so a bad
          // redirect target is caught on the edge after it was loaded.
          if (w_misaligned) begin
            r_fault      <= 2'b01;
            r_ifid_valid <= 1'b0;
            r_state      <= ST_HALT;
          end else if (w_out_of_range) begin
            r_fault      <= 2'b10;
            r_ifid_valid <= 1'b0;
            r_state      <= ST_HALT;
          end else if (if_fetch.redirect_i) begin
            // Word fetched this cycle is wrong-path: drop it.
            r_pc         <= if_fetch.redirect_pc_i;
            r_ifid_valid <= 1'b0;
          end else if (if_fetch.stall_i) begin
            if (if_fetch.flush_i) begin
              r_ifid_valid <= 1'b0;
            end
          end else if (if_fetch.flush_i) begin
            r_pc         <= w_pc_plus4;
            r_ifid_valid <= 1'b0;
          end else begin
            r_ifid_instr  <= if_fetch.imem_rd_i;
            r_ifid_pc     <= r_pc;
            r_ifid_pc4    <= w_pc_plus4;
            r_ifid_valid  <= 1'b1;
            r_pc          <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end

        ST_HALT: r_ifid_valid <= 1'b0;

        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign if_fetch.imem_addr_o   = r_pc;
  assign if_fetch.ifid_instr_o  = r_ifid_instr;
  assign if_fetch.ifid_pc_o     = r_ifid_pc;
  assign if_fetch.ifid_pc4_o    = r_ifid_pc4;
  assign if_fetch.ifid_valid_o  = r_ifid_valid;
  assign if_fetch.fault_o       = r_fault;
  assign if_fetch.fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

  localparam int unsigned IMEM_WORDS = 256;
  localparam longint      PC_LIMIT   = longint'(IMEM_WORDS) * 4;

  logic clk;
  logic rst_n;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(IMEM_WORDS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_fetch(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory, combinational read.
  logic [31:0] mem [IMEM_WORDS];
  assign bus.imem_rd_i = (longint'(bus.imem_addr_o) < PC_LIMIT) ?
                         mem[bus.imem_addr_o[9:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        valid;
    logic [1:0]  fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the stage.
  int          m_state;  // 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_valid;
  logic [1:0]  m_fault;

  function automatic void model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
    m_valid = 0; m_fault = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input logic st, input logic fl, input logic rd,
                                     input logic [31:0] rpc);
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 2) begin
      m_valid = 0;
    end else if (m_pc % 4 != 0) begin
      m_fault = 2'b01; m_valid = 0; m_state = 2;
    end else if (longint'(m_pc) >= PC_LIMIT) begin
      m_fault = 2'b10; m_valid = 0; m_state = 2;
    end else if (rd) begin
      m_pc = rpc; m_valid = 0;
    end else if (st) begin
      if (fl) m_valid = 0;
    end else if (fl) begin
      m_pc = m_pc + 4; m_valid = 0;
    end else begin
      m_instr = mem[m_pc / 4];
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end
  endfunction

  // Drive one cycle's inputs, predict the post-edge outputs, then return at
  // negedge+1 so the new outputs are observable.
  task automatic step(input logic st, input logic fl, input logic rd,
                      input logic [31:0] rpc);
    exp_t e;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    model_edge(st, fl, rd, rpc);
    e.addr = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.ipc4 = m_ipc4;
    e.valid = m_valid; e.fault = m_fault; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Async reset asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_addr",  bus.imem_addr_o,   32'h0);
    chk("rst_instr", bus.ifid_instr_o,  32'h0);
    chk("rst_pc",    bus.ifid_pc_o,     32'h0);
    chk("rst_pc4",   bus.ifid_pc4_o,    32'h0);
    chk("rst_valid", 32'(bus.ifid_valid_o), 32'h0);
    chk("rst_fault", 32'(bus.fault_o),  32'h0);
    chk("rst_count", bus.fetch_count_o, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: outputs are compared at every falling edge that has a prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_addr",  bus.imem_addr_o,   e.addr);
      chk("sb_valid", 32'(bus.ifid_valid_o), 32'(e.valid));
      chk("sb_fault", 32'(bus.fault_o),  32'(e.fault));
      chk("sb_count", bus.fetch_count_o, e.cnt);
      if (e.valid) begin
        chk("sb_instr", bus.ifid_instr_o, e.instr);
        chk("sb_pc",    bus.ifid_pc_o,    e.ipc);
        chk("sb_pc4",   bus.ifid_pc4_o,   e.ipc4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] cnt_before;
    logic [31:0] tgt;
    int          halt_cycles;
    int          r;

    for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;

    rst_n             = 1'b0;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    model_reset();
    @(negedge clk);
    #1;
    do_reset();

    // Boot and first two fetches.
    step(0, 0, 0, 0);
    chk("t1_boot_valid", 32'(bus.ifid_valid_o), 32'h0);
    chk("t1_boot_addr",  bus.imem_addr_o, 32'h0);
    step(0, 0, 0, 0);
    chk("t1_instr0", bus.ifid_instr_o, 32'h11);
    step(0, 0, 0, 0);
    chk("t1_instr1", bus.ifid_instr_o, 32'h22);
    chk("t1_count",  bus.fetch_count_o, 32'd2);

    // Stall two cycles at pc 8, then resume.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_addr",  bus.imem_addr_o, 32'h8);
    chk("t2_count", bus.fetch_count_o, 32'd2);
    step(0, 0, 0, 0);
    chk("t2_instr", bus.ifid_instr_o, 32'h33);

    // Redirect wins over stall.
    step(1, 0, 1, 32'h40);
    chk("t3_addr",  bus.imem_addr_o, 32'h40);
    chk("t3_valid", 32'(bus.ifid_valid_o), 32'h0);
    step(0, 0, 0, 0);
    chk("t3_pc",  bus.ifid_pc_o,  32'h40);
    chk("t3_pc4", bus.ifid_pc4_o, 32'h44);

    // Flush alone at pc 0x10.
    step(0, 0, 1, 32'h10);
    cnt_before = bus.fetch_count_o;
    step(0, 1, 0, 0);
    chk("t4_valid", 32'(bus.ifid_valid_o), 32'h0);
    chk("t4_addr",  bus.imem_addr_o, 32'h14);
    chk("t4_count", bus.fetch_count_o, cnt_before);

    // Misaligned redirect target faults, then halt ignores inputs.
    step(0, 0, 1, 32'h42);
    step(0, 0, 0, 0);
    chk("t5_fault", 32'(bus.fault_o), 32'h1);
    step(1, 0, 1, 32'h80);
    step(0, 1, 0, 0);
    chk("t5_halt_addr", bus.imem_addr_o, 32'h42);
    do_reset();

    // Sequential run off the end of memory.
    for (int i = 0; i < int'(IMEM_WORDS) + 4; i++) step(0, 0, 0, 0);
    chk("t6_fault", 32'(bus.fault_o), 32'h2);
    chk("t6_addr",  bus.imem_addr_o, 32'h400);
    chk("t6_count", bus.fetch_count_o, 32'(IMEM_WORDS));
    do_reset();
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    do_reset();

    // Random phase.
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 2) halt_cycles++;
      if (halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
      r = $urandom_range(0, 99);
      if (r < 80)      tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      else if (r < 90) tgt = 32'h3F0 + 32'($urandom_range(0, 3) * 4);
      else if (r < 95) tgt = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else             tgt = $urandom | 32'h400;
      step(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 8), tgt);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
